// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, reservation-station sizing and the CDB result entry.
package cpu_pkg;

    localparam int unsigned RS_WIDTH   = 3;
    localparam int unsigned NUM_RS     = 8;
    localparam int unsigned OP_WIDTH   = 4;
    localparam int unsigned DATA_WIDTH = 16;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_MOV = 4'd0,
        OP_ADD = 4'd1,
        OP_JMP = 4'd2,
        OP_HLT = 4'd3,
        OP_LD  = 4'd4,
        OP_LDR = 4'd5,
        OP_JEQ = 4'd6
    } opcode_e;

    typedef struct packed {
        logic [RS_WIDTH-1:0]   tag;
        logic [OP_WIDTH-1:0]   op;
        logic [DATA_WIDTH-1:0] val;
    } result_entry_t;

    function automatic result_entry_t make_entry(
        input logic [RS_WIDTH-1:0]   tag,
        input logic [OP_WIDTH-1:0]   op,
        input logic [DATA_WIDTH-1:0] val
    );
        result_entry_t e;
        e.tag = tag;
        e.op  = op;
        e.val = val;
        return e;
    endfunction

endpackage

// File: rtl/result_queue.sv
// Per-source result FIFO: DEPTH entries, wrapping pointers, combinational full/empty/head.
module result_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  result_entry_t push_data,
    input  logic          pop,
    output logic          full_c,
    output logic          empty_c,
    output result_entry_t head_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    result_entry_t    mem_q [DEPTH];
    result_entry_t    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign head_c  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_ok  = push && !full_c;
        pop_ok   = pop && !empty_c;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result queues drained one per cycle by a
// round-robin grant onto registered CDB outputs.
module cdb_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned NSRC   = 2,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NSRC-1:0]        src_valid,
    input  logic [NSRC*TAG_W-1:0]  src_tag,
    input  logic [NSRC*OP_W-1:0]   src_op,
    input  logic [NSRC*DATA_W-1:0] src_val,
    output logic [NSRC-1:0]        src_ready,
    output logic                   cdb_v,
    output logic [TAG_W-1:0]       cdb_tag,
    output logic [OP_W-1:0]        cdb_op,
    output logic [DATA_W-1:0]      cdb_val
);

    localparam int unsigned SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    result_entry_t     push_data [NSRC];
    result_entry_t     head      [NSRC];
    logic [NSRC-1:0]   full;
    logic [NSRC-1:0]   empty;
    logic [NSRC-1:0]   push;
    logic [NSRC-1:0]   pop;

    logic [SRC_W-1:0]  rr_last_q, rr_last_d;
    logic              cdb_v_q, cdb_v_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [OP_W-1:0]   cdb_op_q, cdb_op_d;
    logic [DATA_W-1:0] cdb_val_q, cdb_val_d;

    logic              grant_found;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W-1:0]  cand_idx;
    int unsigned       cand;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        assign src_ready[g] = !full[g] && !reset;
        assign push[g]      = src_valid[g] && src_ready[g];
        assign push_data[g] = make_entry(RS_WIDTH'(src_tag[g*TAG_W +: TAG_W]),
                                         OP_WIDTH'(src_op[g*OP_W +: OP_W]),
                                         DATA_WIDTH'(src_val[g*DATA_W +: DATA_W]));

        result_queue #(
            .DEPTH (DEPTH)
        ) u_queue (
            .clk       (clk),
            .reset     (reset),
            .push      (push[g]),
            .push_data (push_data[g]),
            .pop       (pop[g]),
            .full_c    (full[g]),
            .empty_c   (empty[g]),
            .head_c    (head[g])
        );
    end

    // Round-robin search starting just after the last granted source.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_last_q;
        cand_idx    = rr_last_q;
        cand        = 0;
        pop         = '0;
        rr_last_d   = rr_last_q;
        cdb_v_d     = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_op_d    = cdb_op_q;
        cdb_val_d   = cdb_val_q;

        for (int unsigned k = 1; k <= NSRC; k++) begin
            cand     = (32'(rr_last_q) + k) % NSRC;
            cand_idx = SRC_W'(cand);
            if (!grant_found && !empty[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end

        if (grant_found) begin
            pop[grant_idx] = 1'b1;
            rr_last_d      = grant_idx;
            cdb_v_d        = 1'b1;
            cdb_tag_d      = TAG_W'(head[grant_idx].tag);
            cdb_op_d       = OP_W'(head[grant_idx].op);
            cdb_val_d      = DATA_W'(head[grant_idx].val);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q <= SRC_W'(NSRC - 1);
            cdb_v_q   <= 1'b0;
            cdb_tag_q <= '0;
            cdb_op_q  <= '0;
            cdb_val_q <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            cdb_v_q   <= cdb_v_d;
            cdb_tag_q <= cdb_tag_d;
            cdb_op_q  <= cdb_op_d;
            cdb_val_q <= cdb_val_d;
        end
    end

    assign cdb_v   = cdb_v_q;
    assign cdb_tag = cdb_tag_q;
    assign cdb_op  = cdb_op_q;
    assign cdb_val = cdb_val_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed CDB sequences.
module tb_cdb_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  src_valid;
    logic [5:0]  src_tag;
    logic [7:0]  src_op;
    logic [31:0] src_val;
    logic [1:0]  src_ready;
    logic        cdb_v;
    logic [2:0]  cdb_tag;
    logic [3:0]  cdb_op;
    logic [15:0] cdb_val;

    int n_chk  = 0;
    int n_pass = 0;

    cdb_arbiter #(
        .NSRC   (2),
        .DEPTH  (2),
        .TAG_W  (3),
        .OP_W   (4),
        .DATA_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .src_valid (src_valid),
        .src_tag   (src_tag),
        .src_op    (src_op),
        .src_val   (src_val),
        .src_ready (src_ready),
        .cdb_v     (cdb_v),
        .cdb_tag   (cdb_tag),
        .cdb_op    (cdb_op),
        .cdb_val   (cdb_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [2:0] tag, input logic [3:0] op,
                         input logic [15:0] val);
        src_valid[s]         = 1'b1;
        src_tag[s*3 +: 3]    = tag;
        src_op[s*4 +: 4]     = op;
        src_val[s*16 +: 16]  = val;
    endtask

    task automatic idle(input int s);
        src_valid[s] = 1'b0;
    endtask

    task automatic expect_cdb(input string name, input logic [2:0] tag,
                              input logic [3:0] op, input logic [15:0] val);
        check_eq({name, ".v"},   32'(cdb_v),   32'd1);
        check_eq({name, ".tag"}, 32'(cdb_tag), 32'(tag));
        check_eq({name, ".op"},  32'(cdb_op),  32'(op));
        check_eq({name, ".val"}, 32'(cdb_val), 32'(val));
    endtask

    task automatic expect_idle(input string name);
        check_eq({name, ".v"}, 32'(cdb_v), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        src_valid = '0;
        src_tag   = '0;
        src_op    = '0;
        src_val   = '0;

        // Reset held for three cycles
        repeat (3) tick();
        expect_idle("rst");
        check_eq("rst.ready", 32'(src_ready), 32'h0);
        check_eq("rst.tag",   32'(cdb_tag),   32'h0);
        check_eq("rst.val",   32'(cdb_val),   32'h0);
        reset = 1'b0;
        #1;
        check_eq("rel.ready", 32'(src_ready), 32'h3);
        tick();
        expect_idle("rel");
        check_eq("rel.ready2", 32'(src_ready), 32'h3);

        // Contention from reset priority: FXU first, then LD
        drive(0, 3'd1, 4'd1, 16'h0011);
        drive(1, 3'd5, 4'd4, 16'h0055);
        tick();
        idle(0); idle(1);
        expect_idle("cont.nobypass");
        tick();
        expect_cdb("cont.fxu", 3'd1, 4'd1, 16'h0011);
        tick();
        expect_cdb("cont.ld", 3'd5, 4'd4, 16'h0055);
        tick();
        expect_idle("cont.end");

        // LD fills its queue while FXU competes
        drive(0, 3'd0, 4'd1, 16'h0A01);
        drive(1, 3'd4, 4'd4, 16'h0B01);
        tick();
        expect_idle("full.e1");
        check_eq("full.ready1", 32'(src_ready), 32'h3);
        drive(0, 3'd1, 4'd1, 16'h0A02);
        drive(1, 3'd5, 4'd4, 16'h0B02);
        tick();
        expect_cdb("full.a1", 3'd0, 4'd1, 16'h0A01);
        check_eq("full.ready2", 32'(src_ready), 32'h1);
        drive(0, 3'd2, 4'd1, 16'h0A03);
        drive(1, 3'd6, 4'd5, 16'h0B03);
        tick();
        expect_cdb("full.l1", 3'd4, 4'd4, 16'h0B01);
        check_eq("full.ready3", 32'(src_ready), 32'h2);
        idle(0);
        tick();
        expect_cdb("full.a2", 3'd1, 4'd1, 16'h0A02);
        check_eq("full.ready4", 32'(src_ready), 32'h1);
        idle(1);
        tick();
        expect_cdb("full.l2", 3'd5, 4'd4, 16'h0B02);
        tick();
        expect_cdb("full.a3", 3'd2, 4'd1, 16'h0A03);
        tick();
        expect_cdb("full.l3", 3'd6, 4'd5, 16'h0B03);
        tick();
        expect_idle("full.end");
        check_eq("full.ready5", 32'(src_ready), 32'h3);

        // Single FXU result, then hold of the last broadcast fields
        drive(0, 3'd2, 4'd1, 16'h0007);
        tick();
        idle(0);
        expect_idle("single.k");
        tick();
        expect_cdb("single", 3'd2, 4'd1, 16'h0007);
        tick();
        expect_idle("single.k2");
        check_eq("single.hold_tag", 32'(cdb_tag), 32'd2);
        check_eq("single.hold_val", 32'(cdb_val), 32'h0007);

        // Repeat burst after an FXU grant: LD wins first
        drive(0, 3'd3, 4'd0, 16'h0033);
        drive(1, 3'd6, 4'd5, 16'h0066);
        tick();
        idle(0); idle(1);
        tick();
        expect_cdb("burst2.ld", 3'd6, 4'd5, 16'h0066);
        tick();
        expect_cdb("burst2.fxu", 3'd3, 4'd0, 16'h0033);
        tick();
        expect_idle("burst2.end");

        // JEQ result with branch-taken bit
        drive(0, 3'd7, 4'd6, 16'h0001);
        tick();
        idle(0);
        tick();
        expect_cdb("jeq", 3'd7, 4'd6, 16'h0001);
        tick();
        expect_idle("jeq.end");

        // Reset asserted with results queued and a broadcast in flight
        drive(0, 3'd1, 4'd1, 16'h0C01);
        drive(1, 3'd4, 4'd4, 16'h0D01);
        tick();
        drive(0, 3'd2, 4'd1, 16'h0C02);
        drive(1, 3'd5, 4'd4, 16'h0D02);
        tick();
        idle(0); idle(1);
        expect_cdb("mid.pre", 3'd4, 4'd4, 16'h0D01);
        #3;
        reset = 1'b1;
        #1;
        expect_idle("mid.async");
        check_eq("mid.tag",   32'(cdb_tag),   32'h0);
        check_eq("mid.val",   32'(cdb_val),   32'h0);
        check_eq("mid.ready", 32'(src_ready), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check_eq("mid.ready_rel", 32'(src_ready), 32'h3);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_idle($sformatf("mid.stale%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
